// File: rtl/gpio_bus_responder_if.sv
// Data-bus request/response bundle between the core's load/store unit and
// the GPIO peripheral.
interface gpio_bus_responder_if;
    logic        Mem_Read_i;
    logic        Mem_Write_i;
    logic [31:0] Address_i;
    logic [31:0] Write_Data_i;
    logic [31:0] Read_Data_o;
    logic        Ready_o;

    modport master (
        output Mem_Read_i,
        output Mem_Write_i,
        output Address_i,
        output Write_Data_i,
        input  Read_Data_o,
        input  Ready_o
    );

    modport slave (
        input  Mem_Read_i,
        input  Mem_Write_i,
        input  Address_i,
        input  Write_Data_i,
        output Read_Data_o,
        output Ready_o
    );
endinterface

// File: rtl/gpio_bus_responder.sv
// Memory-mapped GPIO block: OUT/IN/EDGE/IRQ_EN registers, a two-flop input
// synchronizer, sticky rising-edge flags and a maskable level interrupt.
module gpio_bus_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h1001_0024,
    parameter int          NBITS        = 8
) (
    input  logic             clk,
    input  logic             reset,
    gpio_bus_responder_if.slave bus,
    input  logic [NBITS-1:0] gpio_port_in,
    output logic [NBITS-1:0] gpio_port_out,
    output logic             Irq_o
);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic             accept;
    logic             ready;
    logic             write_accept;
    logic             read_accept;
    logic [31:0]      offset;
    logic             in_window;
    logic [1:0]       reg_sel;
    logic             write_out;
    logic             write_edge;
    logic             write_irq_en;
    logic [NBITS-1:0] write_bits;
    logic [NBITS-1:0] clear_mask;
    logic [NBITS-1:0] rise;
    logic [NBITS-1:0] edge_next;
    logic [NBITS-1:0] irq_en_next;
    logic [31:0]      read_value;
    logic             unused_write_bits;

    logic [NBITS-1:0] out_reg;
    logic [NBITS-1:0] edge_flags;
    logic [NBITS-1:0] irq_en;
    logic [NBITS-1:0] sync1;
    logic [NBITS-1:0] sync2;
    logic [NBITS-1:0] prev_sample;
    logic [31:0]      read_data;
    logic             irq_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Requests are only sampled in IDLE, so a held request is taken every other cycle.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Mem_Read_i || bus.Mem_Write_i) begin
                    accept     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Addresses below the base wrap to huge offsets and fail the window check.
    assign offset    = bus.Address_i - BASE_ADDRESS;
    assign in_window = (offset < 32'h0000_0010);
    assign reg_sel   = offset[3:2];

    assign write_accept = accept & bus.Mem_Write_i;
    assign read_accept  = accept & bus.Mem_Read_i & ~bus.Mem_Write_i;

    assign write_out    = write_accept & in_window & (reg_sel == 2'd0);
    assign write_edge   = write_accept & in_window & (reg_sel == 2'd2);
    assign write_irq_en = write_accept & in_window & (reg_sel == 2'd3);

    assign write_bits        = bus.Write_Data_i[NBITS-1:0];
    assign unused_write_bits = ^bus.Write_Data_i[31:NBITS];

    // A fresh rise wins over a same-cycle write-1-to-clear.
    assign clear_mask  = write_edge ? write_bits : '0;
    assign rise        = sync2 & ~prev_sample;
    assign edge_next   = (edge_flags & ~clear_mask) | rise;
    assign irq_en_next = write_irq_en ? write_bits : irq_en;

    always_comb begin
        read_value = '0;
        if (in_window) begin
            case (reg_sel)
                2'd0:    read_value[NBITS-1:0] = out_reg;
                2'd1:    read_value[NBITS-1:0] = sync2;
                2'd2:    read_value[NBITS-1:0] = edge_flags;
                default: read_value[NBITS-1:0] = irq_en;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg     <= '0;
            edge_flags  <= '0;
            irq_en      <= '0;
            sync1       <= '0;
            sync2       <= '0;
            prev_sample <= '0;
            read_data   <= '0;
            irq_reg     <= 1'b0;
        end else begin
            sync1       <= gpio_port_in;
            sync2       <= sync1;
            prev_sample <= sync2;
            edge_flags  <= edge_next;
            irq_en      <= irq_en_next;
            irq_reg     <= |(edge_next & irq_en_next);
            if (write_out) begin
                out_reg <= write_bits;
            end
            if (read_accept) begin
                read_data <= read_value;
            end
        end
    end

    assign bus.Ready_o     = ready;
    assign bus.Read_Data_o = read_data;
    assign gpio_port_out   = out_reg;
    assign Irq_o           = irq_reg;

endmodule

// File: tb/tb_gpio_bus_responder.sv
// Directed bench for gpio_bus_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares on every Ready_o pulse.
module tb_gpio_bus_responder;

    localparam logic [31:0] BASE = 32'h1001_0024;

    typedef struct {
        logic [31:0] rdata;
        logic [7:0]  out;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pins_in;
    logic [7:0] pins_out;
    logic       irq;

    int   num_compared   = 0;
    int   num_mismatched = 0;
    exp_t sb[$];
    exp_t mon_item;
    logic [31:0] model_read = 32'h0;

    gpio_bus_responder_if bus();

    gpio_bus_responder #(
        .BASE_ADDRESS(BASE),
        .NBITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .gpio_port_in(pins_in),
        .gpio_port_out(pins_out),
        .Irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpected(input logic [7:0] exp_out, input string name);
        exp_t e;
        e.rdata = model_read;
        e.out   = exp_out;
        e.name  = name;
        sb.push_back(e);
    endtask

    // One bus transaction: assert, accepted at next edge, drop during Ready_o.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_read, input logic [7:0] exp_out,
                                 input string name);
        if (rd && !wr) model_read = exp_read;
        pushExpected(exp_out, name);
        bus.Mem_Read_i   = rd;
        bus.Mem_Write_i  = wr;
        bus.Address_i    = addr;
        bus.Write_Data_i = wdata;
        stepCycle();
        bus.Mem_Read_i   = 1'b0;
        bus.Mem_Write_i  = 1'b0;
        stepCycle();
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.Ready_o === 1'b1) begin
            if (sb.size() == 0) begin
                num_compared++;
                num_mismatched++;
                $display("[TB] FAIL unexpected_ready: got Ready_o=1, want no response");
            end else begin
                mon_item = sb.pop_front();
                checkOutput({mon_item.name, "_rdata"}, bus.Read_Data_o, mon_item.rdata);
                checkOutput({mon_item.name, "_out"}, {24'h0, pins_out}, {24'h0, mon_item.out});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        pins_in          = 8'hFF;
        bus.Mem_Read_i   = 1'b0;
        bus.Mem_Write_i  = 1'b0;
        bus.Address_i    = 32'h0;
        bus.Write_Data_i = 32'h0;
        stepCycle();
        stepCycle();
        checkOutput("reset_out", {24'h0, pins_out}, 32'h0);
        checkOutput("reset_rdata", bus.Read_Data_o, 32'h0);
        checkOutput("reset_ready", {31'h0, bus.Ready_o}, 32'h0);
        checkOutput("reset_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;

        // Synchronizer latency: first read too early, second sees the pins.
        applyStimulus(1, 0, BASE + 32'h4, 32'h0, 32'h00, 8'h00, "in_early");
        applyStimulus(1, 0, BASE + 32'h4, 32'h0, 32'hFF, 8'h00, "in_synced");

        applyStimulus(0, 1, BASE, 32'h0000_00A5, 32'h0, 8'hA5, "write_out");
        applyStimulus(1, 0, BASE, 32'h0, 32'hA5, 8'hA5, "read_out");

        // The pins rising out of reset leave EDGE=FF; clear it.
        applyStimulus(1, 0, BASE + 32'h8, 32'h0, 32'hFF, 8'hA5, "edge_after_reset");
        applyStimulus(0, 1, BASE + 32'h8, 32'hFF, 32'h0, 8'hA5, "clear_all_edges");
        applyStimulus(1, 0, BASE + 32'h8, 32'h0, 32'h00, 8'hA5, "edge_cleared");

        applyStimulus(0, 1, BASE + 32'hC, 32'h01, 32'h0, 8'hA5, "write_irq_en");
        applyStimulus(1, 0, BASE + 32'hC, 32'h0, 32'h01, 8'hA5, "read_irq_en");
        checkOutput("irq_idle", {31'h0, irq}, 32'h0);

        pins_in = 8'h00;
        repeat (4) stepCycle();
        pins_in = 8'h01;
        stepCycle();
        stepCycle();
        checkOutput("irq_not_yet", {31'h0, irq}, 32'h0);
        stepCycle();
        stepCycle();
        checkOutput("irq_raised", {31'h0, irq}, 32'h1);
        applyStimulus(1, 0, BASE + 32'h8, 32'h0, 32'h01, 8'hA5, "edge_bit0");
        applyStimulus(0, 1, BASE + 32'h8, 32'h01, 32'h0, 8'hA5, "clear_bit0");
        checkOutput("irq_cleared", {31'h0, irq}, 32'h0);
        applyStimulus(1, 0, BASE + 32'h8, 32'h0, 32'h00, 8'hA5, "edge_bit0_gone");

        // Clear of bit3 lands on the same edge as the pin3 rise.
        pins_in = 8'h09;
        stepCycle();
        stepCycle();
        applyStimulus(0, 1, BASE + 32'h8, 32'h08, 32'h0, 8'hA5, "collide_clear");
        applyStimulus(1, 0, BASE + 32'h8, 32'h0, 32'h08, 8'hA5, "edge_bit3_kept");
        checkOutput("irq_masked", {31'h0, irq}, 32'h0);
        applyStimulus(0, 1, BASE + 32'h8, 32'h08, 32'h0, 8'hA5, "clear_bit3");
        applyStimulus(1, 0, BASE + 32'h8, 32'h0, 32'h00, 8'hA5, "edge_bit3_gone");

        applyStimulus(1, 0, 32'h1001_0040, 32'h0, 32'h0, 8'hA5, "oow_above");
        applyStimulus(1, 0, 32'h1001_0020, 32'h0, 32'h0, 8'hA5, "oow_below");
        applyStimulus(1, 0, BASE, 32'h0, 32'hA5, 8'hA5, "out_after_oow");
        applyStimulus(0, 1, BASE + 32'h4, 32'h3C, 32'h0, 8'hA5, "write_in_ro");
        applyStimulus(1, 0, BASE + 32'h4, 32'h0, 32'h09, 8'hA5, "in_unchanged");
        applyStimulus(0, 1, 32'h1001_0034, 32'h77, 32'h0, 8'hA5, "oow_write");
        applyStimulus(1, 0, BASE, 32'h0, 32'hA5, 8'hA5, "out_after_oow_wr");

        // Held write: accepted, skipped in RESP, accepted again.
        pushExpected(8'h5A, "held_first");
        pushExpected(8'h5A, "held_second");
        bus.Mem_Write_i  = 1'b1;
        bus.Address_i    = BASE;
        bus.Write_Data_i = 32'h5A;
        checkOutput("held_ready0", {31'h0, bus.Ready_o}, 32'h0);
        stepCycle();
        checkOutput("held_ready1", {31'h0, bus.Ready_o}, 32'h1);
        stepCycle();
        checkOutput("held_ready2", {31'h0, bus.Ready_o}, 32'h0);
        stepCycle();
        checkOutput("held_ready3", {31'h0, bus.Ready_o}, 32'h1);
        bus.Mem_Write_i = 1'b0;
        stepCycle();
        checkOutput("held_ready4", {31'h0, bus.Ready_o}, 32'h0);
        applyStimulus(1, 0, BASE, 32'h0, 32'h5A, 8'h5A, "read_held");

        applyStimulus(1, 0, BASE + 32'h4, 32'h0, 32'h09, 8'h5A, "in_before_rw");
        applyStimulus(1, 1, BASE, 32'hC3, 32'h0, 8'hC3, "read_write");
        applyStimulus(1, 0, BASE, 32'h0, 32'hC3, 8'hC3, "read_after_rw");

        stepCycle();
        stepCycle();
        checkOutput("scoreboard_drained", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
